// File: rtl/uart_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy counter, threshold
// flags and sticky overflow/underflow error flags.
module uart_fifo #(
  parameter int D_BIT = 8,
  parameter int W     = 3,
  parameter int AF_TH = 2**W - 1,
  parameter int AE_TH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [D_BIT-1:0] i_w_data,
  input  logic             i_rd,
  output logic [D_BIT-1:0] o_r_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_almost_empty,
  output logic             o_almost_full,
  output logic [W:0]       o_count,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam logic [W:0] L_DEPTH = (W+1)'(2**W);
  localparam logic [W:0] L_AF    = (W+1)'(AF_TH);
  localparam logic [W:0] L_AE    = (W+1)'(AE_TH);

  logic [D_BIT-1:0] r_mem [2**W];
  logic [W-1:0]     r_wptr;
  logic [W-1:0]     r_rptr;
  logic [W:0]       r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_rdAccept;
  logic             w_wrAccept;
  logic             w_memWe;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == L_DEPTH);
  assign w_rdAccept = i_rd & ~w_empty;
  // A full FIFO still takes a write when the same edge pops the head.
  assign w_wrAccept = i_wr & (~w_full | w_rdAccept);
  assign w_memWe    = w_wrAccept & ~i_rst & ~i_clr;

  // Storage is deliberately left unreset; only pointers and count define contents.
  always_ff @(posedge i_clk) begin
    if (w_memWe) begin
      r_mem[r_wptr] <= i_w_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wrAccept) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rdAccept) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_wrAccept && !w_rdAccept) begin
        r_count <= r_count + 1'b1;
      end else if (w_rdAccept && !w_wrAccept) begin
        r_count <= r_count - 1'b1;
      end
      if (i_wr && !w_wrAccept) begin
        r_overflow <= 1'b1;
      end
      if (i_rd && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign o_r_data       = w_empty ? '0 : r_mem[r_rptr];
  assign o_empty        = w_empty;
  assign o_full         = w_full;
  assign o_almost_full  = (r_count >= L_AF);
  assign o_almost_empty = (r_count <= L_AE);
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo (D_BIT=8, W=2, AF_TH=3, AE_TH=1) with
// hand-computed expected values for every vector.
module tb_uart_fifo;

   logic       i_clk;
   logic       i_rst;
   logic       i_clr;
   logic       i_wr;
   logic [7:0] i_w_data;
   logic       i_rd;
   logic [7:0] o_r_data;
   logic       o_empty;
   logic       o_full;
   logic       o_almost_empty;
   logic       o_almost_full;
   logic [2:0] o_count;
   logic       o_overflow;
   logic       o_underflow;

   int vectorsApplied = 0;
   int miscompares    = 0;

   uart_fifo #(
      .D_BIT(8),
      .W(2),
      .AF_TH(3),
      .AE_TH(1)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_clr(i_clr),
      .i_wr(i_wr),
      .i_w_data(i_w_data),
      .i_rd(i_rd),
      .o_r_data(o_r_data),
      .o_empty(o_empty),
      .o_full(o_full),
      .o_almost_empty(o_almost_empty),
      .o_almost_full(o_almost_full),
      .o_count(o_count),
      .o_overflow(o_overflow),
      .o_underflow(o_underflow)
   );

   // Free-running 10 ns clock.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorsApplied++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of control/data, lets the edge happen, then returns inputs to idle.
   task automatic applyStimulus(input logic rst, input logic clr, input logic wr, input logic rd, input logic [7:0] data);
      i_rst    = rst;
      i_clr    = clr;
      i_wr     = wr;
      i_rd     = rd;
      i_w_data = data;
      @(posedge i_clk);
      #1;
      i_rst    = 1'b0;
      i_clr    = 1'b0;
      i_wr     = 1'b0;
      i_rd     = 1'b0;
      i_w_data = 8'h00;
   endtask

   // Checks occupancy, head word and all four derived flags against the expected count.
   task automatic checkState(input string tag, input int expCount, input logic [7:0] expData);
      checkOutput({tag, ".count"}, 32'(o_count), 32'(expCount));
      checkOutput({tag, ".r_data"}, 32'(o_r_data), 32'(expData));
      checkOutput({tag, ".empty"}, 32'(o_empty), 32'(expCount == 0));
      checkOutput({tag, ".full"}, 32'(o_full), 32'(expCount == 4));
      checkOutput({tag, ".almost_full"}, 32'(o_almost_full), 32'(expCount >= 3));
      checkOutput({tag, ".almost_empty"}, 32'(o_almost_empty), 32'(expCount <= 1));
   endtask

   task automatic checkErrors(input string tag, input logic expOvf, input logic expUnf);
      checkOutput({tag, ".overflow"}, 32'(o_overflow), 32'(expOvf));
      checkOutput({tag, ".underflow"}, 32'(o_underflow), 32'(expUnf));
   endtask

   // Directed scenario sequence; each step lists its expected state explicitly.
   initial begin
      logic [7:0] fillData [4];
      logic [7:0] drain1 [4];
      logic [7:0] drain2 [4];
      fillData = '{8'h11, 8'h22, 8'h33, 8'h44};
      drain1   = '{8'h22, 8'h33, 8'h44, 8'h00};
      drain2   = '{8'h33, 8'h44, 8'h66, 8'h00};

      i_rst = 1'b1; i_clr = 1'b0; i_wr = 1'b0; i_rd = 1'b0; i_w_data = 8'h00;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      checkState("reset", 0, 8'h00);
      checkErrors("reset", 1'b0, 1'b0);

      $display("[TB] fill to full");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, fillData[i]);
         checkState($sformatf("fill%0d", i), i + 1, 8'h11);
      end

      $display("[TB] overflow and drain");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h55);
      checkState("ovf", 4, 8'h11);
      checkErrors("ovf", 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
         checkState($sformatf("drainA%0d", i), 3 - i, drain1[i]);
      end
      checkErrors("ovfSticky", 1'b1, 1'b0);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      checkState("unfRead", 0, 8'h00);
      checkErrors("unfRead", 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      checkState("clr1", 0, 8'h00);
      checkErrors("clr1", 1'b0, 1'b0);

      $display("[TB] simultaneous read/write while full");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, fillData[i]);
      end
      checkState("refill", 4, 8'h11);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h66);
      checkState("rwFull", 4, 8'h22);
      checkErrors("rwFull", 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
         checkState($sformatf("drainB%0d", i), 3 - i, drain2[i]);
      end

      $display("[TB] simultaneous read/write while empty");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);
      checkState("rwEmpty", 1, 8'hA5);
      checkErrors("rwEmpty", 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      checkState("clr2", 0, 8'h00);

      $display("[TB] clear with pending write");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h02);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h03);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h04);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      checkState("cnt3", 3, 8'h02);
      checkErrors("cnt3", 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h99);
      checkState("clrWr", 0, 8'h00);
      checkErrors("clrWr", 1'b0, 1'b0);

      $display("[TB] reset mid-operation");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h5B);
      checkState("cnt2", 2, 8'h5A);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
      checkState("rstMid", 0, 8'h00);
      checkErrors("rstMid", 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h7E);
      checkState("postRst", 1, 8'h7E);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      checkState("postRstRd", 0, 8'h00);
      checkErrors("postRstRd", 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
